// File: rtl/ahb_sram_ctrl_if.sv
// AHB-lite bus signals between a master (or interconnect) and the SRAM controller slave.
interface ahb_sram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave sequencing a single-port registered-read SRAM: sub-word writes by
// read-modify-write, one wait state on port conflicts, two-cycle ERROR for illegal transfers.
module ahb_sram_ctrl #(
    parameter int unsigned SRAM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    ahb_sram_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_data,
    output logic               sram_wren,
    input  logic [31:0]        sram_q
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_LOOKUP,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_nxt;

    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_AW-1:0] last_addr;
    logic               write_q;
    logic [3:0]         mask_q;

    logic               accept;
    logic               legal;
    logic               need_lookup;
    logic               commit;
    logic               lookup_now;
    logic [SRAM_AW-1:0] new_idx;
    logic [3:0]         new_mask;
    logic               unused_bits;

    assign unused_bits = ^{bus.HADDR[31:SRAM_AW+2], bus.HTRANS[0]};

    assign accept = (state inside {ST_IDLE, ST_DATA, ST_ERR2})
                  & bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal  = (bus.HSIZE == 3'd0)
                  | ((bus.HSIZE == 3'd1) & ~bus.HADDR[0])
                  | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] == 2'b00));
    // Full-word writes skip the lookup, so they never collide with a pending commit.
    assign need_lookup = ~bus.HWRITE | (bus.HSIZE != 3'd2);
    assign commit      = (state == ST_DATA) & write_q;
    assign lookup_now  = accept & legal & need_lookup & ~commit;
    assign new_idx     = bus.HADDR[SRAM_AW+1:2];

    always_comb begin
        new_mask = 4'b1111;
        case (bus.HSIZE)
            3'd0:    new_mask = 4'b0001 << bus.HADDR[1:0];
            3'd1:    new_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: new_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_LOOKUP: state_nxt = ST_DATA;
            ST_ERR1:   state_nxt = ST_ERR2;
            default: begin
                if (accept) begin
                    if (!legal)                    state_nxt = ST_ERR1;
                    else if (need_lookup & commit) state_nxt = ST_LOOKUP;
                    else                           state_nxt = ST_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            mask_q    <= '0;
            last_addr <= '0;
        end else begin
            if (accept & legal) begin
                addr_q  <= new_idx;
                write_q <= bus.HWRITE;
                mask_q  <= new_mask;
            end
            last_addr <= sram_addr;
        end
    end

    always_comb begin
        bus.HREADYOUT = !(state inside {ST_LOOKUP, ST_ERR1});
        bus.HRESP     = state inside {ST_ERR1, ST_ERR2};
        bus.HRDATA    = '0;
        if ((state == ST_DATA) && !write_q) bus.HRDATA = sram_q;

        sram_wren = commit & ~rst;
        // Lanes outside the mask come from the lookup issued one cycle earlier.
        sram_data = '0;
        for (int unsigned i = 0; i < 4; i++)
            sram_data[8*i +: 8] = mask_q[i] ? bus.HWDATA[8*i +: 8] : sram_q[8*i +: 8];

        if (commit)                  sram_addr = addr_q;
        else if (lookup_now)         sram_addr = new_idx;
        else if (state == ST_LOOKUP) sram_addr = addr_q;
        else                         sram_addr = last_addr;
    end

endmodule
